fixed_point_mul_seq: RTL

Sequential, handshaked successor to the combinational fixed-point multiplier. Accepts two signed WIDTH-bit fixed-point operands (DEC_POINT_POS fractional bits), computes the sign-magnitude product with a shift-add datapath over WIDTH cycles, and optionally masks low multiplier bits for approximate, configurable-precision operation. Adds selectable rounding, a saturated WIDTH-bit output with an overflow flag, and valid/ready flow control. It sits between operand producers and accumulators in the approximate-multiplication datapath.

---
 rtl/fixed_point_mul_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fixed_point_mul_seq.sv
// Sequential sign-magnitude fixed-point multiplier with a maskable shift-add datapath,
// selectable rounding, saturation and valid/ready handshakes on both sides.
module fixed_point_mul_seq #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned DEC_POINT_POS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic [WIDTH-3:0]     Conf_Bit_Mask,
   input  logic                 Round_Mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   R,
   output logic [WIDTH-1:0]     R_sat,
   output logic                 Ovf
);

   localparam int unsigned PW     = 2 * WIDTH;
   localparam int unsigned CW     = $clog2(WIDTH);
   localparam bit          RND_EN = (DEC_POINT_POS > 0);
   localparam int unsigned RND_SH = (DEC_POINT_POS > 0) ? DEC_POINT_POS - 1 : 0;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [PW-1:0] SMAX = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic [PW-1:0] SMIN = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_POST, S_DONE} state_t;

   state_t            r_state, w_next;
   logic [CW-1:0]     r_cnt;
   logic [PW-1:0]     r_mcand, r_acc;
   logic [WIDTH-1:0]  r_mplier, r_en;
   logic              r_sign, r_round;

   logic              w_accept;
   logic [WIDTH-1:0]  w_mag_a, w_mag_b;
   logic [PW-1:0]     w_rnd, w_q, w_r;
   logic [WIDTH-1:0]  w_r_sat;
   logic              w_ovf;

   assign in_ready  = (r_state == S_IDLE) && !rst;
   assign out_valid = (r_state == S_DONE);
   assign w_accept  = in_valid & in_ready;

   // Two's-complement negate in WIDTH bits: the most negative value maps to 2^(WIDTH-1).
   assign w_mag_a = A[WIDTH-1] ? -A : A;
   assign w_mag_b = B[WIDTH-1] ? -B : B;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_MUL;
         S_MUL:   if (r_cnt == LAST_CNT) w_next = S_POST;
         S_POST:  w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_rnd   = (r_round && RND_EN) ? (PW'(1) << RND_SH) : '0;
      w_q     = (r_acc + w_rnd) >> DEC_POINT_POS;
      w_r     = r_sign ? -w_q : w_q;
      w_r_sat = w_r[WIDTH-1:0];
      w_ovf   = 1'b0;
      if ($signed(w_r) > $signed(SMAX)) begin
         w_r_sat = {1'b0, {(WIDTH - 1){1'b1}}};
         w_ovf   = 1'b1;
      end else if ($signed(w_r) < $signed(SMIN)) begin
         w_r_sat = {1'b1, {(WIDTH - 1){1'b0}}};
         w_ovf   = 1'b1;
      end
   end

   // Multiplicand shifts left and multiplier/enable shift right, so bit 0 is always iteration i.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_en     <= '0;
         r_sign   <= 1'b0;
         r_round  <= 1'b0;
         R        <= '0;
         R_sat    <= '0;
         Ovf      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                  r_mplier <= w_mag_b;
                  r_en     <= {2'b11, Conf_Bit_Mask};
                  r_sign   <= A[WIDTH-1] ^ B[WIDTH-1];
                  r_round  <= Round_Mode;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            S_MUL: begin
               r_acc    <= r_acc + ((r_mplier[0] & r_en[0]) ? r_mcand : '0);
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_en     <= r_en >> 1;
               r_cnt    <= r_cnt + CW'(1);
            end
            S_POST: begin
               R     <= w_r;
               R_sat <= w_r_sat;
               Ovf   <= w_ovf;
            end
            default: ;
         endcase
      end
   end

endmodule
